conj_scale_stream: RTL and testbench

Streaming, parametrised conjugate-and-scale stage for the FFT datapath. It replaces the fixed 16-point, 64-bit, divide-by-2^28 combinational conjugator with a two-stage pipelined unit that handles one complex sample per cycle under valid/ready flow control. Input and output widths, shift amount and frame length are parameters. Conjugation and rounding are selected per sample, and the block adds output saturation and frame tracking. It sits between the forward FFT core and the IFFT-via-FFT feedback path, or the output formatter.

---
 rtl/conj_scale_stream.sv | 147 ++++++++++++++
 tb/tb_conj_scale_stream.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conj_scale_stream.sv
// conj_scale_stream
//   Two-stage valid/ready pipeline that scales a complex sample by 2^-SHIFT,
//   optionally conjugates it and saturates it to W_OUT bits. Frames are N
//   samples long; the frame index travels with each sample.
//
//   Stage 1 registers the scaled components (truncate or round half away
//   from zero). Stage 2 registers the conjugated and clamped result, which
//   drives the outputs directly.
//
// Ports
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   in_valid/in_ready           input handshake
//   in_real, in_im              signed W_IN-bit input components
//   in_last                     end-of-frame marker from upstream
//   conj_en, round_mode         per-sample attributes, captured with the data
//   out_valid/out_ready         output handshake
//   out_real, out_im            signed W_OUT-bit results
//   out_last                    sample carries frame index N-1
//   sat_flag                    sticky: some component was clamped
//   frame_err                   sticky: in_last arrived at an index other than N-1

// Per-component scaler: sign/magnitude so that both rounding modes are
// symmetric about zero. One extra bit keeps |most negative| representable.
module csc_scale #(
  parameter int W_IN  = 64,
  parameter int SHIFT = 28
) (
  input  logic [W_IN-1:0] x,
  input  logic            rnd,
  output logic [W_IN:0]   q
);
  localparam logic [W_IN:0] HALF = {{W_IN{1'b0}}, 1'b1} << (SHIFT-1);

  logic          neg;
  logic [W_IN:0] xe, mag, sum, shq;

  assign neg = x[W_IN-1];
  assign xe  = {x[W_IN-1], x};
  assign mag = neg ? -xe : xe;
  assign sum = mag + (rnd ? HALF : '0);
  assign shq = sum >> SHIFT;
  assign q   = neg ? -shq : shq;
endmodule

module conj_scale_stream #(
  parameter int W_IN  = 64,
  parameter int W_OUT = 64,
  parameter int SHIFT = 28,
  parameter int N     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W_IN-1:0]  in_real,
  input  logic signed [W_IN-1:0]  in_im,
  input  logic                    in_last,
  input  logic                    conj_en,
  input  logic                    round_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [W_OUT-1:0] out_real,
  output logic signed [W_OUT-1:0] out_im,
  output logic                    out_last,
  output logic                    sat_flag,
  output logic                    frame_err
);
  localparam int LANES = 2;   // lane 0 = real, lane 1 = imaginary
  localparam int IW    = $clog2(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N-1);
  localparam logic [W_IN:0] OMAX = ({{W_IN{1'b0}}, 1'b1} << (W_OUT-1)) - 1'b1;
  localparam logic [W_IN:0] OMIN = ~OMAX;

  logic [2:1] vld_pipe;
  logic       s1_en, s2_en, in_xfer;

  // A stage may load when empty or when its contents leave this cycle.
  assign s2_en    = !vld_pipe[2] || out_ready;
  assign s1_en    = !vld_pipe[1] || s2_en;
  assign in_ready = s1_en;
  assign in_xfer  = in_valid && in_ready;
  assign out_valid = vld_pipe[2];

  // Stage 1 datapath
  logic [LANES-1:0][W_IN-1:0] in_vec;
  logic [LANES-1:0][W_IN:0]   q_comb, s1_q;
  logic                       s1_conj;
  logic [IW-1:0]              s1_idx, idx;

  assign in_vec = {in_im, in_real};

  for (genvar g = 0; g < LANES; g++) begin : g_scale
    csc_scale #(.W_IN(W_IN), .SHIFT(SHIFT)) u_scale (
      .x   (in_vec[g]),
      .rnd (round_mode),
      .q   (q_comb[g])
    );
  end

  // Stage 2 datapath: negate after scaling, then clamp
  logic [LANES-1:0][W_IN:0]    v;
  logic [LANES-1:0][W_OUT-1:0] res;
  logic [LANES-1:0]            sat_lane;

  for (genvar g = 0; g < LANES; g++) begin : g_sat
    logic hi, lo;
    assign v[g] = (g == 1 && s1_conj) ? -s1_q[g] : s1_q[g];
    assign hi   = $signed(v[g]) > $signed(OMAX);
    assign lo   = $signed(v[g]) < $signed(OMIN);
    assign sat_lane[g] = hi || lo;
    assign res[g] = hi ? OMAX[W_OUT-1:0] : (lo ? OMIN[W_OUT-1:0] : v[g][W_OUT-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      s1_q      <= '0;
      s1_conj   <= 1'b0;
      s1_idx    <= '0;
      idx       <= '0;
      frame_err <= 1'b0;
      out_real  <= '0;
      out_im    <= '0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      if (s1_en) vld_pipe[1] <= in_valid;
      if (in_xfer) begin
        s1_q    <= q_comb;
        s1_conj <= conj_en;
        s1_idx  <= idx;
        // in_last always restarts the count; early ones are an error
        idx     <= in_last ? '0 : idx + 1'b1;
        if (in_last && idx != IDX_LAST) frame_err <= 1'b1;
      end
      if (s2_en) vld_pipe[2] <= vld_pipe[1];
      // Output registers only change when a real sample moves in, so they
      // hold stable under backpressure.
      if (s2_en && vld_pipe[1]) begin
        out_real <= res[0];
        out_im   <= res[1];
        out_last <= (s1_idx == IDX_LAST);
        if (|sat_lane) sat_flag <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_conj_scale_stream.sv
module tb_conj_scale_stream;
  localparam int W_IN = 64, W_OUT = 16, SHIFT = 28, N = 16;

  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_last = 0, conj_en = 0, round_mode = 0;
  logic signed [W_IN-1:0] in_real = 0, in_im = 0;
  logic out_valid, out_ready = 0, out_last, sat_flag, frame_err;
  logic signed [W_OUT-1:0] out_real, out_im;

  conj_scale_stream #(.W_IN(W_IN), .W_OUT(W_OUT), .SHIFT(SHIFT), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_im(in_im), .in_last(in_last), .conj_en(conj_en),
    .round_mode(round_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_im(out_im), .out_last(out_last),
    .sat_flag(sat_flag), .frame_err(frame_err));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // ---------------- reference model ----------------
  typedef struct { longint re; longint im; bit last; } exp_t;
  exp_t expq[$];
  int   midx = 0;

  function automatic longint exp_comp(input longint x, input bit rnd, input bit neg);
    logic signed [65:0] a, mag, q;
    a   = x;
    mag = (a < 0) ? -a : a;
    if (rnd) mag = mag + 66'sd134217728;
    q = mag / 66'sd268435456;
    if (a < 0) q = -q;
    if (neg)   q = -q;
    if (q > 66'sd32767)  q = 66'sd32767;
    if (q < -66'sd32768) q = -66'sd32768;
    return longint'(q);
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // ---------------- output monitor ----------------
  longint got_re [0:255];
  longint got_im [0:255];
  int     ocnt = 0;
  int     lastq[$];
  bit     prev_stall = 0;
  logic signed [W_OUT-1:0] p_re, p_im;
  logic   p_last;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        tests++;
        if (!out_valid || out_real !== p_re || out_im !== p_im || out_last !== p_last) begin
          fails++;
          $display("FAIL stall_hold: got v=%0b re=%0d im=%0d last=%0b, want v=1 re=%0d im=%0d last=%0b",
                   out_valid, out_real, out_im, out_last, p_re, p_im, p_last);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL extra_output: got re=%0d im=%0d, want no output", out_real, out_im);
        end else begin
          exp_t e;
          e = expq.pop_front();
          if (longint'(out_real) != e.re || longint'(out_im) != e.im || out_last !== e.last) begin
            fails++;
            $display("FAIL stream[%0d]: got re=%0d im=%0d last=%0b, want re=%0d im=%0d last=%0b",
                     ocnt, out_real, out_im, out_last, e.re, e.im, e.last);
          end
        end
        if (ocnt < 256) begin
          got_re[ocnt] = longint'(out_real);
          got_im[ocnt] = longint'(out_im);
        end
        if (out_last) lastq.push_back(ocnt);
        ocnt++;
      end
      prev_stall = out_valid && !out_ready;
      p_re = out_real; p_im = out_im; p_last = out_last;
    end
  end

  // ---------------- out_ready driver ----------------
  int rdy_mode = 0;   // 0 low, 1 high, 2 random
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input longint re, input longint im, input bit cj, input bit rd, input bit lst);
    bit done = 0, acc;
    int n = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1; in_real = re; in_im = im; conj_en = cj; round_mode = rd; in_last = lst;
    while (!done) begin
      #1 acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        done = 1;
        e.re = exp_comp(re, rd, 1'b0);
        e.im = exp_comp(im, rd, cj);
        e.last = (midx == N-1);
        midx = lst ? 0 : (midx + 1) % N;
        expq.push_back(e);
      end else begin
        n++;
        if (n > 200) begin
          tests++; fails++;
          $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, want acceptance");
          done = 1;
        end else @(negedge clk);
      end
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", expq.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    expq.delete();
    midx = 0;
  endtask

  localparam longint P62 = longint'(1) <<< 62;
  localparam longint M63 = longint'(64'h8000_0000_0000_0000);
  localparam longint X63 = longint'(64'h7FFF_FFFF_FFFF_FFFF);

  initial begin
    int base;
    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_real", out_real, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_in_ready", in_ready, 1);

    // basic scaling and latency
    rdy_mode = 1;
    @(posedge clk); #3;
    base = ocnt;
    send(805306368, 805306368, 1, 0, 0);
    @(negedge clk);
    chk("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2_valid", out_valid, 1);
    chk("basic_real", longint'(out_real), 3);
    chk("basic_im", longint'(out_im), -3);

    // rounding
    send(-402653184, 0, 0, 0, 0);
    send(-402653184, 0, 0, 1, 0);
    send(134217728, 0, 0, 0, 0);
    send(134217728, 0, 0, 1, 0);
    send(0, -805306368, 0, 0, 0);
    drain();
    chk("trunc_neg1p5", got_re[base+1], -1);
    chk("round_neg1p5", got_re[base+2], -2);
    chk("trunc_0p5", got_re[base+3], 0);
    chk("round_0p5", got_re[base+4], 1);
    chk("noconj_im", got_im[base+5], -3);
    chk("sat_before", sat_flag, 0);

    // saturation
    send(P62, -P62, 1, 0, 0);
    send(-P62, 0, 0, 0, 0);
    send(M63, X63, 0, 1, 0);
    drain();
    chk("sat_real_pos", got_re[base+6], 32767);
    chk("sat_im_conj", got_im[base+6], 32767);
    chk("sat_real_neg", got_re[base+7], -32768);
    chk("sat_real_min", got_re[base+8], -32768);
    chk("sat_im_max", got_im[base+8], 32767);
    chk("sat_flag_set", sat_flag, 1);

    // backpressure ramp
    do_reset();
    rdy_mode = 2;
    base = ocnt;
    for (int k = 0; k < 40; k++) begin
      bit [1:0] kb;
      kb = 2'(k);
      send((longint'(k) <<< 28) + k * 3000000, -(longint'(k) <<< 27) - k * 777, kb[0], kb[1], 0);
    end
    drain();
    chk("bp_count", ocnt - base, 40);
    chk("bp_ramp_last_re", got_re[base+39], 39);

    // framing
    rdy_mode = 1;
    do_reset();
    lastq.delete();
    base = ocnt;
    for (int k = 0; k < 48; k++) send(longint'(k) <<< 28, 0, 0, 0, (k % 16) == 15);
    for (int k = 0; k < 5; k++) send(0, 0, 0, 0, 0);
    chk("frame_err_clean", frame_err, 0);
    send(0, 0, 0, 0, 1);
    chk("frame_err_set", frame_err, 1);
    for (int k = 0; k < 16; k++) send(longint'(k) <<< 28, 0, 0, 0, k == 15);
    drain();
    chk("last_count", lastq.size(), 4);
    if (lastq.size() == 4) begin
      chk("last_pos0", lastq[0] - base, 15);
      chk("last_pos1", lastq[1] - base, 31);
      chk("last_pos2", lastq[2] - base, 47);
      chk("last_pos3", lastq[3] - base, 69);
    end

    // reset mid-stream with both stages full
    rdy_mode = 0;
    @(posedge clk); #3;
    send(longint'(7) <<< 28, 0, 0, 0, 0);
    send(longint'(9) <<< 28, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_out_real", longint'(out_real), 7);
    repeat (2) @(negedge clk);
    do_reset();
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sat", sat_flag, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    rdy_mode = 1;
    @(posedge clk); #3;
    lastq.delete();
    base = ocnt;
    for (int k = 0; k < 16; k++) send(longint'(k) <<< 28, 0, 0, 0, k == 15);
    drain();
    chk("post_rst_count", ocnt - base, 16);
    chk("post_rst_last_n", lastq.size(), 1);
    if (lastq.size() == 1) chk("post_rst_last_pos", lastq[0] - base, 15);
    chk("post_rst_first", got_re[base], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end
endmodule
